// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS-subset decode stage.
//   - Primary opcode and R-type funct codes of the supported instructions.
//   - ALU operation encoding carried to the execute stage on alu_op_ex.
//   - Link register index used by JAL.
//   - ctrl_t: per-instruction control bundle produced by the decoder.
// No ports; imported with import mips_pkg::*.
package mips_pkg;

    // Primary opcodes (ir[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (ir[5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // Link register written by JAL
    localparam logic [4:0] REG_RA = 5'd31;

    // ALU operation encoding seen by the execute stage
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_LUI  = 4'd10,
        ALU_PASS = 4'd11
    } alu_op_e;

    // Control bundle for one decoded instruction
    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        logic    writes;
        logic    mem_read;
        logic    mem_write;
        logic    legal;
    } ctrl_t;

endpackage

// File: rtl/regfile.sv
// regfile
// 2-read / 1-write register file with r0 hard-wired to zero.
// Reads are asynchronous; a read of the register being written in the same
// cycle returns the incoming write data so decode sees writeback results
// without an extra cycle.
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset (clears all regs)
//   rs_addr, rt_addr    read indices
//   rs_data, rt_data    read data (combinational)
//   we, waddr, wdata    synchronous write port, ignored for r0
module regfile
    import mips_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int REG_BITS   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_BITS-1:0]   rs_addr,
    input  logic [REG_BITS-1:0]   rt_addr,
    output logic [WORD_WIDTH-1:0] rs_data,
    output logic [WORD_WIDTH-1:0] rt_data,
    input  logic                  we,
    input  logic [REG_BITS-1:0]   waddr,
    input  logic [WORD_WIDTH-1:0] wdata
);

    localparam int NUM_REGS = 2 ** REG_BITS;

    logic [WORD_WIDTH-1:0] regs_q [NUM_REGS];
    logic [WORD_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  write_ok;

    // r0 is never written so it keeps its reset value of zero
    assign write_ok = we && (waddr != '0);

    always_comb begin
        regs_d = regs_q;
        if (write_ok) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Write-through: the value being written this cycle wins over the stored one
    always_comb begin
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (write_ok && (waddr == rs_addr)) begin
            rs_data = wdata;
        end else begin
            rs_data = regs_q[rs_addr];
        end
    end

    always_comb begin
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (write_ok && (waddr == rt_addr)) begin
            rt_data = wdata;
        end else begin
            rt_data = regs_q[rt_addr];
        end
    end

endmodule

// File: rtl/decode.sv
// decode
// Instruction-decode stage of the MIPS-subset pipeline. Decodes ir_id, reads
// operands from the register file, resolves jumps/branches combinationally
// for fetch, and registers controls and operands into the ID/EX register.
// Ports:
//   clk, rst_n                 clock / asynchronous active-low reset
//   pc_id, ir_id               word address and instruction from fetch
//   wb_we, wb_addr, wb_data    writeback port into the register file
//   jump, target               same-cycle redirect to fetch
//   pc_ex .. illegal_ex        ID/EX pipeline register outputs
module decode
    import mips_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int REG_BITS   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] pc_id,
    input  logic [31:0]           ir_id,
    input  logic                  wb_we,
    input  logic [REG_BITS-1:0]   wb_addr,
    input  logic [WORD_WIDTH-1:0] wb_data,
    output logic                  jump,
    output logic [WORD_WIDTH-1:0] target,
    output logic [WORD_WIDTH-1:0] pc_ex,
    output logic [WORD_WIDTH-1:0] rs_data_ex,
    output logic [WORD_WIDTH-1:0] rt_data_ex,
    output logic [WORD_WIDTH-1:0] imm_ex,
    output logic [4:0]            shamt_ex,
    output logic [REG_BITS-1:0]   dst_ex,
    output logic [3:0]            alu_op_ex,
    output logic                  alu_src_ex,
    output logic                  reg_write_ex,
    output logic                  mem_read_ex,
    output logic                  mem_write_ex,
    output logic                  illegal_ex
);

    localparam int EXT_BITS = WORD_WIDTH - 16;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] rs_data;
        logic [WORD_WIDTH-1:0] rt_data;
        logic [WORD_WIDTH-1:0] imm;
        logic [4:0]            shamt;
        logic [REG_BITS-1:0]   dst;
        logic [3:0]            alu_op;
        logic                  alu_src;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  illegal;
    } idex_t;

    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [REG_BITS-1:0]   rs_idx;
    logic [REG_BITS-1:0]   rt_idx;
    logic [REG_BITS-1:0]   rd_idx;
    logic [15:0]           imm16;
    logic [WORD_WIDTH-1:0] imm_sext;
    logic [WORD_WIDTH-1:0] imm_zext;
    logic [WORD_WIDTH-1:0] imm_upper;
    logic [WORD_WIDTH-1:0] branch_target;
    logic [WORD_WIDTH-1:0] jump_target;
    logic [WORD_WIDTH-1:0] rs_val;
    logic [WORD_WIDTH-1:0] rt_val;
    logic                  operands_equal;
    logic                  is_nop;

    ctrl_t                 ctrl;
    logic [REG_BITS-1:0]   dst_sel;
    logic [WORD_WIDTH-1:0] imm_val;
    logic [4:0]            shamt_val;
    logic                  jump_raw;
    logic [WORD_WIDTH-1:0] target_raw;

    idex_t                 ex_d;
    idex_t                 ex_q;

    assign opcode    = ir_id[31:26];
    assign funct     = ir_id[5:0];
    assign rs_idx    = ir_id[25:21];
    assign rt_idx    = ir_id[20:16];
    assign rd_idx    = ir_id[15:11];
    assign imm16     = ir_id[15:0];
    assign is_nop    = (ir_id == 32'h0);

    assign imm_sext  = {{EXT_BITS{imm16[15]}}, imm16};
    assign imm_zext  = {{EXT_BITS{1'b0}}, imm16};
    assign imm_upper = {imm16, {EXT_BITS{1'b0}}};

    // Branch offsets are relative to the delay-slot address (pc+1)
    assign branch_target = pc_id + WORD_WIDTH'(1) + imm_sext;
    assign jump_target   = {pc_id[WORD_WIDTH-1:26], ir_id[25:0]};

    regfile #(
        .WORD_WIDTH (WORD_WIDTH),
        .REG_BITS   (REG_BITS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .rs_addr (rs_idx),
        .rt_addr (rt_idx),
        .rs_data (rs_val),
        .rt_data (rt_val),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    assign operands_equal = (rs_val == rt_val);

    // Instruction decode: controls, destination, immediate and redirect
    always_comb begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src   = 1'b0;
        ctrl.writes    = 1'b0;
        ctrl.mem_read  = 1'b0;
        ctrl.mem_write = 1'b0;
        ctrl.legal     = 1'b1;
        dst_sel        = '0;
        imm_val        = '0;
        shamt_val      = '0;
        jump_raw       = 1'b0;
        target_raw     = branch_target;

        case (opcode)
            OP_RTYPE: begin
                ctrl.writes = 1'b1;
                dst_sel     = rd_idx;
                case (funct)
                    FN_ADDU: ctrl.alu_op = ALU_ADD;
                    FN_SUBU: ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_XOR:  ctrl.alu_op = ALU_XOR;
                    FN_NOR:  ctrl.alu_op = ALU_NOR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    FN_SLL: begin
                        ctrl.alu_op = ALU_SLL;
                        shamt_val   = ir_id[10:6];
                    end
                    FN_SRL: begin
                        ctrl.alu_op = ALU_SRL;
                        shamt_val   = ir_id[10:6];
                    end
                    FN_SRA: begin
                        ctrl.alu_op = ALU_SRA;
                        shamt_val   = ir_id[10:6];
                    end
                    FN_JR: begin
                        ctrl.writes = 1'b0;
                        dst_sel     = '0;
                        jump_raw    = 1'b1;
                        target_raw  = rs_val;
                    end
                    default: begin
                        ctrl.writes = 1'b0;
                        ctrl.legal  = 1'b0;
                    end
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                ctrl.alu_src = 1'b1;
                ctrl.writes  = 1'b1;
                dst_sel      = rt_idx;
                imm_val      = imm_sext;
                case (opcode)
                    OP_SLTI: ctrl.alu_op = ALU_SLT;
                    OP_ANDI: begin
                        ctrl.alu_op = ALU_AND;
                        imm_val     = imm_zext;
                    end
                    OP_ORI: begin
                        ctrl.alu_op = ALU_OR;
                        imm_val     = imm_zext;
                    end
                    OP_XORI: begin
                        ctrl.alu_op = ALU_XOR;
                        imm_val     = imm_zext;
                    end
                    OP_LUI: begin
                        ctrl.alu_op = ALU_LUI;
                        imm_val     = imm_upper;
                    end
                    OP_LW:   ctrl.mem_read = 1'b1;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                imm_val        = imm_sext;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.alu_op = ALU_SUB;
                imm_val     = imm_sext;
                jump_raw    = (opcode == OP_BEQ) ? operands_equal : !operands_equal;
            end
            OP_J: begin
                jump_raw   = 1'b1;
                target_raw = jump_target;
            end
            OP_JAL: begin
                // Link value skips the delay slot
                ctrl.alu_op  = ALU_PASS;
                ctrl.alu_src = 1'b1;
                ctrl.writes  = 1'b1;
                dst_sel      = REG_RA;
                imm_val      = pc_id + WORD_WIDTH'(2);
                jump_raw     = 1'b1;
                target_raw   = jump_target;
            end
            default: ctrl.legal = 1'b0;
        endcase

        // The all-zero word would otherwise decode as SLL r0; keep it a clean bubble
        if (is_nop) begin
            ctrl.alu_op = ALU_ADD;
        end
    end

    // Redirect is held off while the pipeline is in reset
    assign jump   = rst_n && jump_raw;
    assign target = rst_n ? target_raw : '0;

    // ID/EX next-state; unsupported opcodes leave only pc and the illegal flag
    always_comb begin
        ex_d    = '0;
        ex_d.pc = pc_id;
        if (!ctrl.legal) begin
            ex_d.illegal = 1'b1;
        end else begin
            ex_d.rs_data   = rs_val;
            ex_d.rt_data   = rt_val;
            ex_d.imm       = imm_val;
            ex_d.shamt     = shamt_val;
            ex_d.alu_op    = ctrl.alu_op;
            ex_d.alu_src   = ctrl.alu_src;
            ex_d.mem_read  = ctrl.mem_read;
            ex_d.mem_write = ctrl.mem_write;
            ex_d.dst       = ctrl.writes ? dst_sel : '0;
            ex_d.reg_write = ctrl.writes && (dst_sel != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign pc_ex        = ex_q.pc;
    assign rs_data_ex   = ex_q.rs_data;
    assign rt_data_ex   = ex_q.rt_data;
    assign imm_ex       = ex_q.imm;
    assign shamt_ex     = ex_q.shamt;
    assign dst_ex       = ex_q.dst;
    assign alu_op_ex    = ex_q.alu_op;
    assign alu_src_ex   = ex_q.alu_src;
    assign reg_write_ex = ex_q.reg_write;
    assign mem_read_ex  = ex_q.mem_read;
    assign mem_write_ex = ex_q.mem_write;
    assign illegal_ex   = ex_q.illegal;

endmodule

// File: tb/tb_decode.sv
// tb_decode
// Self-checking bench for decode: directed cases plus randomized instruction
// streams, each predicted by an instruction-level reference model and queued
// on a scoreboard that a separate monitor drains after every clock edge.
module tb_decode;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_id;
    logic [31:0] ir_id;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        jump;
    logic [31:0] target;
    logic [31:0] pc_ex;
    logic [31:0] rs_data_ex;
    logic [31:0] rt_data_ex;
    logic [31:0] imm_ex;
    logic [4:0]  shamt_ex;
    logic [4:0]  dst_ex;
    logic [3:0]  alu_op_ex;
    logic        alu_src_ex;
    logic        reg_write_ex;
    logic        mem_read_ex;
    logic        mem_write_ex;
    logic        illegal_ex;

    always #5 clk = ~clk;

    decode dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_id        (pc_id),
        .ir_id        (ir_id),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .jump         (jump),
        .target       (target),
        .pc_ex        (pc_ex),
        .rs_data_ex   (rs_data_ex),
        .rt_data_ex   (rt_data_ex),
        .imm_ex       (imm_ex),
        .shamt_ex     (shamt_ex),
        .dst_ex       (dst_ex),
        .alu_op_ex    (alu_op_ex),
        .alu_src_ex   (alu_src_ex),
        .reg_write_ex (reg_write_ex),
        .mem_read_ex  (mem_read_ex),
        .mem_write_ex (mem_write_ex),
        .illegal_ex   (illegal_ex)
    );

    typedef struct packed {
        logic [31:0] id;
        logic        jump;
        logic [31:0] target;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [4:0]  dst;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_rf [32];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          next_id  = 0;

    logic [5:0] r_functs [11] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2A, 6'h00, 6'h02, 6'h03, 6'h08};
    logic [5:0] i_ops    [12] = '{6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                  6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] bad_ops  [4]  = '{6'h3F, 6'h01, 6'h20, 6'h06};

    task automatic checkOutput(input string name, input logic [31:0] id,
                               input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s (item %0d): got %h, expected %h", name, id, got, want);
        end
    endtask

    function automatic logic [31:0] readModel(input logic [4:0] a, input logic we,
                                              input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (we && wa == a) return wd;
        return model_rf[a];
    endfunction

    // Instruction-level semantics: what EX must see for this instruction
    function automatic exp_t predict(input logic [31:0] pc, input logic [31:0] ir,
                                     input logic we, input logic [4:0] wa,
                                     input logic [31:0] wd);
        exp_t        e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sx;
        logic [31:0] zx;
        logic [4:0]  dest;
        logic        writes;
        logic        legal;
        op     = ir[31:26];
        fn     = ir[5:0];
        sx     = {{16{ir[15]}}, ir[15:0]};
        zx     = {16'h0, ir[15:0]};
        a      = readModel(ir[25:21], we, wa, wd);
        b      = readModel(ir[20:16], we, wa, wd);
        e      = '0;
        e.pc   = pc;
        writes = 1'b0;
        legal  = 1'b1;
        dest   = 5'd0;
        if (ir == 32'h0) return e;
        e.rs = a;
        e.rt = b;
        if (op == 6'h00) begin
            writes = 1'b1;
            dest   = ir[15:11];
            case (fn)
                6'h21: e.alu_op = ALU_ADD;
                6'h23: e.alu_op = ALU_SUB;
                6'h24: e.alu_op = ALU_AND;
                6'h25: e.alu_op = ALU_OR;
                6'h26: e.alu_op = ALU_XOR;
                6'h27: e.alu_op = ALU_NOR;
                6'h2A: e.alu_op = ALU_SLT;
                6'h00: begin e.alu_op = ALU_SLL; e.shamt = ir[10:6]; end
                6'h02: begin e.alu_op = ALU_SRL; e.shamt = ir[10:6]; end
                6'h03: begin e.alu_op = ALU_SRA; e.shamt = ir[10:6]; end
                6'h08: begin writes = 1'b0; e.jump = 1'b1; e.target = a; end
                default: legal = 1'b0;
            endcase
        end else begin
            case (op)
                6'h09: begin e.alu_op = ALU_ADD; e.imm = sx; end
                6'h0A: begin e.alu_op = ALU_SLT; e.imm = sx; end
                6'h0C: begin e.alu_op = ALU_AND; e.imm = zx; end
                6'h0D: begin e.alu_op = ALU_OR;  e.imm = zx; end
                6'h0E: begin e.alu_op = ALU_XOR; e.imm = zx; end
                6'h0F: begin e.alu_op = ALU_LUI; e.imm = {ir[15:0], 16'h0}; end
                6'h23: begin e.alu_op = ALU_ADD; e.imm = sx; e.mem_read = 1'b1; end
                6'h2B: begin e.alu_op = ALU_ADD; e.imm = sx; e.mem_write = 1'b1;
                             e.alu_src = 1'b1; end
                6'h04, 6'h05: begin
                    e.alu_op = ALU_SUB;
                    e.imm    = sx;
                    e.jump   = (op == 6'h04) ? (a == b) : (a != b);
                    e.target = pc + 32'd1 + sx;
                end
                6'h02: begin e.jump = 1'b1; e.target = {pc[31:26], ir[25:0]}; end
                6'h03: begin
                    e.alu_op  = ALU_PASS;
                    e.alu_src = 1'b1;
                    e.imm     = pc + 32'd2;
                    e.jump    = 1'b1;
                    e.target  = {pc[31:26], ir[25:0]};
                    writes    = 1'b1;
                    dest      = 5'd31;
                end
                default: legal = 1'b0;
            endcase
            if (legal && op != 6'h2B && op != 6'h04 && op != 6'h05 &&
                op != 6'h02 && op != 6'h03) begin
                e.alu_src = 1'b1;
                writes    = 1'b1;
                dest      = ir[20:16];
            end
        end
        if (!legal) begin
            e         = '0;
            e.pc      = pc;
            e.illegal = 1'b1;
            return e;
        end
        e.dst       = writes ? dest : 5'd0;
        e.reg_write = writes && (dest != 5'd0);
        return e;
    endfunction

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] ir,
                                 input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        pc_id   = pc;
        ir_id   = ir;
        wb_we   = we;
        wb_addr = wa;
        wb_data = wd;
        e       = predict(pc, ir, we, wa, wd);
        e.id    = 32'(next_id);
        next_id++;
        sb_q.push_back(e);
        if (we && wa != 5'd0) model_rf[wa] = wd;
    endtask

    function automatic logic [31:0] randInstr();
        int          k;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rnd;
        k   = $urandom_range(0, 25);
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        rnd = $urandom;
        if (k < 11) return {6'h00, rs, rt, rd, rnd[10:6], r_functs[k]};
        if (k < 23) return {i_ops[k-11], rs, rt, rnd[15:0]};
        if (k == 23) return {6'h00, rs, rt, rd, 5'd0, 6'h20};
        return {bad_ops[rnd[17:16]], rnd[25:0]};
    endfunction

    // Monitor: one ID/EX result per clock edge for each queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("jump",      e.id, 32'(jump),         32'(e.jump));
                if (e.jump) checkOutput("target", e.id, target, e.target);
                checkOutput("pc_ex",     e.id, pc_ex,             e.pc);
                checkOutput("rs_data",   e.id, rs_data_ex,        e.rs);
                checkOutput("rt_data",   e.id, rt_data_ex,        e.rt);
                checkOutput("imm",       e.id, imm_ex,            e.imm);
                checkOutput("shamt",     e.id, 32'(shamt_ex),     32'(e.shamt));
                checkOutput("dst",       e.id, 32'(dst_ex),       32'(e.dst));
                checkOutput("alu_op",    e.id, 32'(alu_op_ex),    32'(e.alu_op));
                checkOutput("alu_src",   e.id, 32'(alu_src_ex),   32'(e.alu_src));
                checkOutput("reg_write", e.id, 32'(reg_write_ex), 32'(e.reg_write));
                checkOutput("mem_read",  e.id, 32'(mem_read_ex),  32'(e.mem_read));
                checkOutput("mem_write", e.id, 32'(mem_write_ex), 32'(e.mem_write));
                checkOutput("illegal",   e.id, 32'(illegal_ex),   32'(e.illegal));
            end
        end
    end

    initial begin
        rst_n   = 1'b1;
        pc_id   = 32'h0;
        ir_id   = 32'h0;
        wb_we   = 1'b0;
        wb_addr = 5'd0;
        wb_data = 32'h0;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_pc_ex",     0, pc_ex, 32'h0);
        checkOutput("reset_reg_write", 0, 32'(reg_write_ex), 32'h0);
        checkOutput("reset_alu_op",    0, 32'(alu_op_ex), 32'h0);
        checkOutput("reset_jump",      0, 32'(jump), 32'h0);
        checkOutput("reset_target",    0, target, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Write-through: ADDU r3,r5,r0 while r5 <= 0x1234
        applyStimulus(32'h4, 32'h00A01821, 1'b1, 5'd5, 32'h00001234);
        @(posedge clk);
        #1;
        checkOutput("wt_rs_data", 0, rs_data_ex, 32'h00001234);
        checkOutput("wt_dst",     0, 32'(dst_ex), 32'd3);
        // Set r1 for branch tests
        applyStimulus(32'h8, 32'h00000000, 1'b1, 5'd1, 32'hCAFE0001);
        // BEQ r1,r1,-2 at 0x40
        applyStimulus(32'h40, 32'h1021FFFE, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("beq_jump",   0, 32'(jump), 32'h1);
        checkOutput("beq_target", 0, target, 32'h3F);
        // BNE r1,r1 not taken
        applyStimulus(32'h41, 32'h1421FFFE, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("bne_jump", 0, 32'(jump), 32'h0);
        // JAL 0x100 at 0x10
        applyStimulus(32'h10, 32'h0C000100, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("jal_target", 0, target, 32'h100);
        @(posedge clk);
        #1;
        checkOutput("jal_imm", 0, imm_ex, 32'h12);
        checkOutput("jal_dst", 0, 32'(dst_ex), 32'd31);
        // Immediate extension: ORI, ADDIU, LUI with 0x8000
        applyStimulus(32'h20, 32'h34028000, 1'b0, 5'd0, 32'h0);
        applyStimulus(32'h21, 32'h24028000, 1'b0, 5'd0, 32'h0);
        applyStimulus(32'h22, 32'h3C028000, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("lui_imm", 0, imm_ex, 32'h80000000);
        // Illegal opcode 0x3F, ADDU to r0, writeback to r0 then read r0
        applyStimulus(32'h30, 32'hFC000000, 1'b0, 5'd0, 32'h0);
        applyStimulus(32'h31, 32'h00220021, 1'b1, 5'd0, 32'hDEADBEEF);
        applyStimulus(32'h32, 32'h00001821, 1'b0, 5'd0, 32'h0);

        // Mid-run reset with a J in decode
        applyStimulus(32'h50, 32'h08000123, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_pc_ex",   0, pc_ex, 32'h0);
        checkOutput("midrst_jump",    0, 32'(jump), 32'h0);
        checkOutput("midrst_target",  0, target, 32'h0);
        checkOutput("midrst_illegal", 0, 32'(illegal_ex), 32'h0);
        for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        applyStimulus(32'h60, 32'h00A01821, 1'b0, 5'd0, 32'h0);

        // Randomized stream
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom, randInstr(), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)), $urandom);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 0, 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
